// File: rtl/jacaranda_pkg.sv
// ---------------------------------------------------------------------------
// jacaranda_pkg
// Shared definitions for the program loader and instruction memory side of
// the jacaranda CPU.
//   - loader_state_t : loader FSM states (CHECK/ERR only reachable when the
//                      loader is built with PROG_LOADER_CHECKSUM_EN).
//   - ADDR_W_DEFAULT / DATA_W_DEFAULT : instruction memory geometry.
//   - IMEM_DEPTH     : number of instruction memory words.
//   - last_index()   : index of the final data byte for a length byte.
// ---------------------------------------------------------------------------
package jacaranda_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;
    localparam int IMEM_DEPTH     = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_t;

    // A length byte of 0 encodes a full IMEM_DEPTH image, so the last index
    // is (len - 1) modulo the memory depth: 0 -> 255, 1 -> 0, 3 -> 2.
    function automatic logic [7:0] last_index(input logic [7:0] len);
        return 8'((int'(len) + IMEM_DEPTH - 1) % IMEM_DEPTH);
    endfunction

endpackage

// File: rtl/prog_checksum.sv
// ---------------------------------------------------------------------------
// prog_checksum
// 8-bit modular accumulator for the loader's image checksum.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   clear   in   synchronous clear of the running sum (wins over add_en)
//   add_en  in   add data into the running sum this cycle
//   data    in   byte to add, also the candidate checksum byte
//   is_zero out  (sum + data) mod 256 == 0, combinational
// ---------------------------------------------------------------------------
module prog_checksum (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic       is_zero
);

    logic [7:0] sum;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum <= 8'h00;
        end else if (clear) begin
            sum <= 8'h00;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

    // The checksum byte is good when it brings the running sum back to zero.
    assign is_zero = (8'(sum + data) == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Receives a length-prefixed byte stream over valid/ready and writes it into
// instruction memory starting at address 0. The CPU is held stopped
// (cpu_run=0) until the complete image has been written.
//
// Build option: define PROG_LOADER_CHECKSUM_EN to expect one checksum byte
// after the data; the image is accepted only if (sum of data + checksum)
// mod 256 == 0, otherwise the loader parks in ERR with error=1. Without the
// macro the checksum path is absent and error is tied low.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_data      in   stream byte
//   in_valid     in   in_data is valid
//   in_ready     out  byte accepted this cycle (combinational)
//   reload       in   synchronous request to restart and await a new image
//   imem_w_en    out  instruction memory write strobe
//   imem_w_addr  out  instruction memory write address
//   imem_w_data  out  instruction memory write data
//   cpu_run      out  CPU may fetch and execute
//   busy         out  loader is in LOAD or CHECK
//   error        out  checksum mismatch, sticky until reload or reset
// ---------------------------------------------------------------------------
module prog_loader
    import jacaranda_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_w_en,
    output logic [ADDR_W-1:0] imem_w_addr,
    output logic [DATA_W-1:0] imem_w_data,
    output logic              cpu_run,
    output logic              busy,
    output logic              error
);

    loader_state_t     state;
    logic [ADDR_W-1:0] count;
    logic [7:0]        last_idx;
    logic              accept;
    logic              last_byte;

    // reload takes priority: a byte offered alongside reload is not accepted.
    assign in_ready  = ((state == ST_IDLE) || (state == ST_LOAD) ||
                        (state == ST_CHECK)) && !reload;
    assign accept    = in_valid && in_ready;
    assign last_byte = (count == ADDR_W'(last_idx));

`ifdef PROG_LOADER_CHECKSUM_EN
    logic sum_ok;
    logic error_q;

    prog_checksum u_checksum (
        .clock   (clock),
        .reset   (reset),
        .clear   (reload || (state == ST_IDLE && accept)),
        .add_en  (state == ST_LOAD && accept),
        .data    (in_data),
        .is_zero (sum_ok)
    );

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // NOTE: instruction memory itself lives outside this block and is never
    // cleared; only the write port registers are given reset values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            last_idx    <= 8'h00;
            imem_w_en   <= 1'b0;
            imem_w_addr <= '0;
            imem_w_data <= '0;
            cpu_run     <= 1'b0;
            busy        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            error_q     <= 1'b0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse per accepted data byte.
            imem_w_en <= 1'b0;

            if (reload) begin
                state   <= ST_IDLE;
                count   <= '0;
                cpu_run <= 1'b0;
                busy    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                error_q <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            last_idx <= last_index(in_data);
                            count    <= '0;
                            state    <= ST_LOAD;
                            busy     <= 1'b1;
                        end
                    end

                    ST_LOAD: begin
                        if (accept) begin
                            imem_w_en   <= 1'b1;
                            imem_w_addr <= count;
                            imem_w_data <= DATA_W'(in_data);
                            // Wraps to 0 only on the 256th byte, which is last.
                            count       <= count + 1'b1;
                            if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state <= ST_CHECK;
`else
                                state <= ST_FLUSH;
                                busy  <= 1'b0;
`endif
                            end
                        end
                    end

`ifdef PROG_LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        if (accept) begin
                            busy  <= 1'b0;
                            state <= sum_ok ? ST_FLUSH : ST_ERR;
                        end
                    end

                    // error rises one edge after the bad checksum is taken.
                    ST_ERR: error_q <= 1'b1;
`endif

                    // Gives the final write a full cycle before DONE.
                    ST_FLUSH: state <= ST_DONE;

                    // cpu_run trails entry to DONE by one edge, so it can
                    // never overlap the last memory write.
                    ST_DONE: cpu_run <= 1'b1;

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed testbench for prog_loader. Works in both builds: when
// PROG_LOADER_CHECKSUM_EN is defined each image is followed by a correct
// checksum byte and the checksum scenarios are added.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic       clock;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       reload;
    logic       imem_w_en;
    logic [7:0] imem_w_addr;
    logic [7:0] imem_w_data;
    logic       cpu_run;
    logic       busy;
    logic       error;

    int compared   = 0;
    int mismatched = 0;

    // Write monitor: records every write the memory would capture.
    int         wr_cnt  [256];
    logic [7:0] mem_seen[256];

    prog_loader dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .reload      (reload),
        .imem_w_en   (imem_w_en),
        .imem_w_addr (imem_w_addr),
        .imem_w_data (imem_w_data),
        .cpu_run     (cpu_run),
        .busy        (busy),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && imem_w_en) begin
            wr_cnt[imem_w_addr]   = wr_cnt[imem_w_addr] + 1;
            mem_seen[imem_w_addr] = imem_w_data;
        end
    end

    // One clock: drive inputs at the falling edge, return 1 ns after the
    // following rising edge so registered outputs can be sampled.
    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clock);
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        in_valid = 1'b0;
        reload   = 1'b1;
        @(posedge clock);
        #1;
        reload = 1'b0;
    endtask

    task automatic clear_log();
        for (int a = 0; a < 256; a++) begin
            wr_cnt[a]   = 0;
            mem_seen[a] = 8'h00;
        end
    endtask

    // With the checksum build, append the byte that zeroes the running sum.
    task automatic finish_image(input logic [7:0] sum);
`ifdef PROG_LOADER_CHECKSUM_EN
        step(1'b1, 8'(8'h00 - sum));
`else
        sum = sum;
`endif
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear_log();
        #12;
        compared += 7;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (imem_w_en !== 1'b0) begin mismatched++; $display("FAIL reset_w_en got %b want 0", imem_w_en); end
        if (imem_w_addr !== 8'h00) begin mismatched++; $display("FAIL reset_w_addr got %h want 00", imem_w_addr); end
        if (imem_w_data !== 8'h00) begin mismatched++; $display("FAIL reset_w_data got %h want 00", imem_w_data); end
        if (cpu_run !== 1'b0) begin mismatched++; $display("FAIL reset_cpu_run got %b want 0", cpu_run); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        if (error !== 1'b0) begin mismatched++; $display("FAIL reset_error got %b want 0", error); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] img [3] = '{8'h11, 8'h22, 8'h33};
        step(1'b1, 8'h03);
        compared += 2;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy got %b want 1", busy); end
        if (imem_w_en !== 1'b0) begin mismatched++; $display("FAIL basic_len_no_write got %b want 0", imem_w_en); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, img[i]);
            compared++;
            if (imem_w_en !== 1'b1 || imem_w_addr !== 8'(i) || imem_w_data !== img[i] || cpu_run !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_write%0d got en=%b %h@%h run=%b want 1 %h@%h run=0",
                         i, imem_w_en, imem_w_data, imem_w_addr, cpu_run, img[i], 8'(i));
            end
        end
`ifndef PROG_LOADER_CHECKSUM_EN
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_flush got %b want 0", busy); end
`endif
        finish_image(8'h66);
        step(1'b0, 8'h00);
        compared++;
        if (cpu_run !== 1'b0 || imem_w_en !== 1'b0) begin
            mismatched++; $display("FAIL basic_run_early got run=%b en=%b want 0 0", cpu_run, imem_w_en);
        end
        step(1'b0, 8'h00);
        compared += 3;
        if (cpu_run !== 1'b1) begin mismatched++; $display("FAIL basic_run got %b want 1", cpu_run); end
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL basic_ready_done got %b want 0", in_ready); end
        if (wr_cnt[0] != 1 || wr_cnt[1] != 1 || wr_cnt[2] != 1 || wr_cnt[3] != 0) begin
            mismatched++;
            $display("FAIL basic_wr_counts got %0d %0d %0d %0d want 1 1 1 0", wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3]);
        end
        // Bytes offered in DONE are ignored.
        step(1'b1, 8'h99);
        compared++;
        if (imem_w_en !== 1'b0 || cpu_run !== 1'b1) begin
            mismatched++; $display("FAIL basic_done_ignores got en=%b run=%b want 0 1", imem_w_en, cpu_run);
        end
    endtask

    task automatic test_reload();
        @(negedge clock);
        in_valid = 1'b0;
        reload   = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reload_ready_low got %b want 0", in_ready); end
        @(posedge clock);
        #1;
        reload = 1'b0;
        #1;
        compared += 3;
        if (cpu_run !== 1'b0) begin mismatched++; $display("FAIL reload_run got %b want 0", cpu_run); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reload_ready got %b want 1", in_ready); end
        if (error !== 1'b0) begin mismatched++; $display("FAIL reload_error got %b want 0", error); end
        // reload beats a simultaneous length byte in IDLE.
        @(negedge clock);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        @(posedge clock);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reload_priority_busy got %b want 0", busy); end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] img [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        clear_log();
        step(1'b1, 8'h04);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'hEE);
            compared++;
            if (imem_w_en !== 1'b0) begin mismatched++; $display("FAIL toggle_idle%0d got en=%b want 0", i, imem_w_en); end
            step(1'b1, img[i]);
            compared++;
            if (imem_w_en !== 1'b1 || imem_w_addr !== 8'(i) || imem_w_data !== img[i]) begin
                mismatched++;
                $display("FAIL toggle_write%0d got en=%b %h@%h want 1 %h@%h", i, imem_w_en, imem_w_data, imem_w_addr, img[i], 8'(i));
            end
        end
        finish_image(8'h8A);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        compared += 2;
        if (cpu_run !== 1'b1) begin mismatched++; $display("FAIL toggle_run got %b want 1", cpu_run); end
        if (mem_seen[3] !== 8'hA4 || wr_cnt[3] != 1 || wr_cnt[4] != 0) begin
            mismatched++; $display("FAIL toggle_log got %h x%0d next x%0d want a4 x1 next x0", mem_seen[3], wr_cnt[3], wr_cnt[4]);
        end
    endtask

    task automatic test_len_256();
        int         bad = 0;
        logic [7:0] sum = 8'h00;
        pulse_reload();
        clear_log();
        step(1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i) ^ 8'h5A);
            sum = sum + (8'(i) ^ 8'h5A);
        end
        finish_image(sum);
        step(1'b0, 8'h00);
        compared++;
        if (cpu_run !== 1'b0) begin mismatched++; $display("FAIL len256_run_early got %b want 0", cpu_run); end
        step(1'b0, 8'h00);
        compared++;
        if (cpu_run !== 1'b1) begin mismatched++; $display("FAIL len256_run got %b want 1", cpu_run); end
        for (int a = 0; a < 256; a++) begin
            if (wr_cnt[a] != 1 || mem_seen[a] !== (8'(a) ^ 8'h5A)) bad++;
        end
        compared += 2;
        if (bad != 0) begin mismatched++; $display("FAIL len256_image got %0d bad addresses want 0", bad); end
        if (wr_cnt[0] != 1) begin mismatched++; $display("FAIL len256_addr0 got %0d writes want 1", wr_cnt[0]); end
    endtask

    task automatic test_async_reset();
        pulse_reload();
        step(1'b1, 8'h05);
        step(1'b1, 8'hB1);
        step(1'b1, 8'hB2);
        #2;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        compared += 6;
        if (imem_w_en !== 1'b0) begin mismatched++; $display("FAIL areset_w_en got %b want 0", imem_w_en); end
        if (imem_w_addr !== 8'h00) begin mismatched++; $display("FAIL areset_w_addr got %h want 00", imem_w_addr); end
        if (imem_w_data !== 8'h00) begin mismatched++; $display("FAIL areset_w_data got %h want 00", imem_w_data); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL areset_busy got %b want 0", busy); end
        if (cpu_run !== 1'b0) begin mismatched++; $display("FAIL areset_run got %b want 0", cpu_run); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL areset_ready got %b want 1", in_ready); end
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 8'h01);
        step(1'b1, 8'h7F);
        compared++;
        if (imem_w_en !== 1'b1 || imem_w_addr !== 8'h00 || imem_w_data !== 8'h7F) begin
            mismatched++; $display("FAIL areset_reload_write got en=%b %h@%h want 1 7f@00", imem_w_en, imem_w_data, imem_w_addr);
        end
        finish_image(8'h7F);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        compared++;
        if (cpu_run !== 1'b1) begin mismatched++; $display("FAIL areset_reload_run got %b want 1", cpu_run); end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum_ok();
        pulse_reload();
        step(1'b1, 8'h02);
        step(1'b1, 8'h10);
        step(1'b1, 8'h20);
        compared++;
        if (imem_w_addr !== 8'h01 || imem_w_data !== 8'h20 || busy !== 1'b1) begin
            mismatched++; $display("FAIL csum_ok_write got %h@%h busy=%b want 20@01 busy=1", imem_w_data, imem_w_addr, busy);
        end
        step(1'b1, 8'hD0);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        compared++;
        if (cpu_run !== 1'b1 || error !== 1'b0) begin
            mismatched++; $display("FAIL csum_ok_result got run=%b err=%b want 1 0", cpu_run, error);
        end
    endtask

    task automatic test_checksum_bad();
        pulse_reload();
        step(1'b1, 8'h02);
        step(1'b1, 8'h10);
        step(1'b1, 8'h20);
        step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        compared++;
        if (error !== 1'b1 || cpu_run !== 1'b0) begin
            mismatched++; $display("FAIL csum_bad_result got err=%b run=%b want 1 0", error, cpu_run);
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        compared++;
        if (error !== 1'b1 || cpu_run !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++; $display("FAIL csum_bad_sticky got err=%b run=%b rdy=%b want 1 0 0", error, cpu_run, in_ready);
        end
        pulse_reload();
        #1;
        compared++;
        if (error !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL csum_bad_reload got err=%b rdy=%b busy=%b want 0 1 0", error, in_ready, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_toggle_valid();
        test_len_256();
        test_async_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum_ok();
        test_checksum_bad();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
